// File: rtl/cache_req_sequencer.sv
// Issues NUM_REQ sequential single-outstanding read requests to a cache and tallies hits/misses.
// Optional feature: define CACHE_REQ_CHECKSUM_EN to add a 32-bit running sum of resp_data.
module cache_req_sequencer #(
  parameter int ADDR_W     = 15,
  parameter int NUM_REQ    = 8192,
  parameter int START_ADDR = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic              resp_hit,
  input  logic [31:0]       resp_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`ifdef CACHE_REQ_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [15:0]       LAST_REQ = 16'(NUM_REQ);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       issued, issued_n;
  logic [15:0]       hits_n, misses_n;

`ifdef CACHE_REQ_CHECKSUM_EN
  logic [31:0] csum_n;
`else
  // resp_data only feeds the checksum; fold it into a deliberately unused net.
  logic unused_resp_data;
  assign unused_resp_data = ^resp_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_addr   <= '0;
      issued     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
`ifdef CACHE_REQ_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state      <= state_n;
      req_addr   <= addr_n;
      issued     <= issued_n;
      hit_count  <= hits_n;
      miss_count <= misses_n;
`ifdef CACHE_REQ_CHECKSUM_EN
      checksum   <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = req_addr;
    issued_n = issued;
    hits_n   = hit_count;
    misses_n = miss_count;
`ifdef CACHE_REQ_CHECKSUM_EN
    csum_n   = checksum;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = ISSUE;
          addr_n   = START_A;
          issued_n = '0;
          hits_n   = '0;
          misses_n = '0;
`ifdef CACHE_REQ_CHECKSUM_EN
          csum_n   = '0;
`endif
        end
      end
      ISSUE: begin
        if (req_ready) state_n = WAIT;
      end
      WAIT: begin
        if (resp_valid) begin
          issued_n = issued + 16'd1;
          // Address arithmetic is ADDR_W wide, so it wraps to 0 on its own.
          addr_n   = req_addr + 1'b1;
          if (resp_hit) begin
            if (hit_count != '1) hits_n = hit_count + 16'd1;
          end else begin
            if (miss_count != '1) misses_n = miss_count + 16'd1;
          end
`ifdef CACHE_REQ_CHECKSUM_EN
          csum_n   = checksum + resp_data;
`endif
          state_n  = (issued_n == LAST_REQ) ? DONE : ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_valid = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Directed bench: two instances share stimulus (START_ADDR 1024 and 32766, NUM_REQ 4).
// Optional checksum checks are enabled by CACHE_REQ_CHECKSUM_EN.
module tb_cache_req_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, req_ready, resp_valid, resp_hit;
  logic [31:0] resp_data;

  logic        a_req_valid, a_busy, a_done;
  logic [14:0] a_req_addr;
  logic [15:0] a_hit_count, a_miss_count;
  logic        b_req_valid, b_busy, b_done;
  logic [14:0] b_req_addr;
  logic [15:0] b_hit_count, b_miss_count;
`ifdef CACHE_REQ_CHECKSUM_EN
  logic [31:0] a_checksum, b_checksum;
`endif

  int          tests = 0;
  int          fails = 0;
  int          exp_hit, exp_miss;
  logic [31:0] exp_csum;

  always #5 clk = ~clk;

  cache_req_sequencer #(.ADDR_W(15), .NUM_REQ(4), .START_ADDR(1024)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .busy(a_busy), .done(a_done), .hit_count(a_hit_count), .miss_count(a_miss_count)
`ifdef CACHE_REQ_CHECKSUM_EN
    , .checksum(a_checksum)
`endif
  );

  cache_req_sequencer #(.ADDR_W(15), .NUM_REQ(4), .START_ADDR(32766)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .busy(b_busy), .done(b_done), .hit_count(b_hit_count), .miss_count(b_miss_count)
`ifdef CACHE_REQ_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, a_req_valid}, 32'd0);
    chk({tag, "_addr"},  {17'd0, a_req_addr},  32'd0);
    chk({tag, "_busy"},  {31'd0, a_busy},      32'd0);
    chk({tag, "_done"},  {31'd0, a_done},      32'd0);
    chk({tag, "_hit"},   {16'd0, a_hit_count}, 32'd0);
    chk({tag, "_miss"},  {16'd0, a_miss_count}, 32'd0);
    chk({tag, "_b_addr"}, {17'd0, b_req_addr}, 32'd0);
`ifdef CACHE_REQ_CHECKSUM_EN
    chk({tag, "_csum"},  a_checksum, 32'd0);
`endif
  endtask

  // Called at a falling edge while idle/done; leaves the DUTs in ISSUE.
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_csum = 32'd0;
    chk("kick_busy", {31'd0, a_busy}, 32'd1);
    chk("kick_done", {31'd0, a_done}, 32'd0);
    chk("kick_hit",  {16'd0, a_hit_count}, 32'd0);
    chk("kick_miss", {16'd0, a_miss_count}, 32'd0);
`ifdef CACHE_REQ_CHECKSUM_EN
    chk("kick_csum", a_checksum, 32'd0);
`endif
  endtask

  // One request/response transaction; optional ISSUE stall and start pulse in WAIT.
  task automatic do_req(input logic hit, input logic [31:0] data, input logic [31:0] ea,
                        input logic [31:0] eb, input int stall, input logic pulse_start);
    chk("req_valid", {31'd0, a_req_valid}, 32'd1);
    chk("a_addr", {17'd0, a_req_addr}, ea);
    chk("b_addr", {17'd0, b_req_addr}, eb);
    for (int i = 0; i < stall; i++) begin
      req_ready = 1'b0; resp_valid = 1'b1; resp_hit = 1'b1; resp_data = 32'h1234;
      @(negedge clk);
      chk("stall_valid", {31'd0, a_req_valid}, 32'd1);
      chk("stall_addr",  {17'd0, a_req_addr}, ea);
      chk("stall_b_addr", {17'd0, b_req_addr}, eb);
      chk("stall_hit",   {16'd0, a_hit_count}, exp_hit);
      chk("stall_miss",  {16'd0, a_miss_count}, exp_miss);
    end
    resp_valid = 1'b0;
    req_ready  = 1'b1;
    @(negedge clk);
    req_ready  = 1'b0;
    chk("wait_valid", {31'd0, a_req_valid}, 32'd0);
    chk("wait_busy",  {31'd0, a_busy}, 32'd1);
    if (pulse_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_start_valid", {31'd0, a_req_valid}, 32'd0);
      chk("ign_start_hit", {16'd0, a_hit_count}, exp_hit);
    end
    resp_valid = 1'b1; resp_hit = hit; resp_data = data;
    @(negedge clk);
    resp_valid = 1'b0;
    if (hit) exp_hit++; else exp_miss++;
    exp_csum = exp_csum + data;
    chk("resp_hit",  {16'd0, a_hit_count}, exp_hit);
    chk("resp_miss", {16'd0, a_miss_count}, exp_miss);
`ifdef CACHE_REQ_CHECKSUM_EN
    chk("resp_csum", a_checksum, exp_csum);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_hit = 1'b0; resp_data = 32'd0;
    exp_hit = 0; exp_miss = 0; exp_csum = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_start_valid", {31'd0, a_req_valid}, 32'd0);
    end

    // Run 1: hit pattern 0,1,1,1 with a stall, a wrap on u_b, and an ignored start.
    kick();
    do_req(1'b0, 32'hFFFF_FFFF, 1024, 32766, 0, 1'b0);
    do_req(1'b1, 32'h0000_0002, 1025, 32767, 5, 1'b0);
    do_req(1'b1, 32'h0000_0000, 1026, 0,     0, 1'b1);
    do_req(1'b1, 32'h0000_0000, 1027, 1,     0, 1'b0);
    chk("r1_done",   {31'd0, a_done}, 32'd1);
    chk("r1_b_done", {31'd0, b_done}, 32'd1);
    chk("r1_busy",   {31'd0, a_busy}, 32'd0);
    chk("r1_valid",  {31'd0, a_req_valid}, 32'd0);
    chk("r1_hit",    {16'd0, a_hit_count}, 32'd3);
    chk("r1_miss",   {16'd0, a_miss_count}, 32'd1);
`ifdef CACHE_REQ_CHECKSUM_EN
    chk("r1_csum",   a_checksum, 32'h0000_0001);
`endif
    resp_valid = 1'b1; resp_hit = 1'b0; resp_data = 32'h55;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("done_ign_miss", {16'd0, a_miss_count}, 32'd1);
    chk("done_hold",     {31'd0, a_done}, 32'd1);

    // Run 2: restart from DONE, then asynchronous reset during WAIT of the 3rd request.
    kick();
    chk("r2_addr", {17'd0, a_req_addr}, 32'd1024);
    do_req(1'b1, 32'h5, 1024, 32766, 0, 1'b0);
    do_req(1'b0, 32'h6, 1025, 32767, 0, 1'b0);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("r2_wait_busy", {31'd0, a_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, a_req_valid}, 32'd0);
      chk("post_rst_busy",  {31'd0, a_busy}, 32'd0);
    end

    // Run 3: full run after reset.
    kick();
    do_req(1'b1, 32'h10, 1024, 32766, 0, 1'b0);
    do_req(1'b1, 32'h20, 1025, 32767, 2, 1'b0);
    do_req(1'b0, 32'h30, 1026, 0,     0, 1'b0);
    do_req(1'b0, 32'h40, 1027, 1,     0, 1'b0);
    chk("r3_done", {31'd0, a_done}, 32'd1);
    chk("r3_hit",  {16'd0, a_hit_count}, 32'd2);
    chk("r3_miss", {16'd0, a_miss_count}, 32'd2);
`ifdef CACHE_REQ_CHECKSUM_EN
    chk("r3_csum", a_checksum, 32'h0000_00A0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_req_sequencer.md
CACHE_REQ_SEQUENCER -- requirements
Module: cache_req_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width of the data memory.
REQ-002 SHALL have parameter NUM_REQ, default 8192, number of read requests per run (1..65535).
REQ-003 SHALL have parameter START_ADDR, default 1024, first word address issued.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a run.
REQ-007 SHALL have port req_valid  output  1  read request to the cache is valid.
REQ-008 SHALL have port req_addr  output  ADDR_W  word address of the request.
REQ-009 SHALL have port req_ready  input  1  cache accepts the request this cycle.
REQ-010 SHALL have port resp_valid  input  1  cache returns read data this cycle.
REQ-011 SHALL have port resp_hit  input  1  returned data was a cache hit; sampled with resp_valid.
REQ-012 SHALL have port resp_data  input  32  returned word; sampled with resp_valid.
REQ-013 SHALL have port busy  output  1  run in progress.
REQ-014 SHALL have port done  output  1  run complete; held until next start or reset.
REQ-015 SHALL have port hit_count  output  16  responses with resp_hit=1 in current run.
REQ-016 SHALL have port miss_count  output  16  responses with resp_hit=0 in current run.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-018 SHALL, in IDLE or DONE on start=1: clear counters, load req_addr=START_ADDR, clear done, go to ISSUE next cycle.
REQ-019 SHALL assert req_valid only in ISSUE; req_addr stable while req_valid=1 and req_ready=0.
REQ-020 SHALL, in ISSUE with req_ready=1: go to WAIT; at most one request outstanding.
REQ-021 SHALL, in WAIT with resp_valid=1: increment hit_count or miss_count per resp_hit, increment issued counter, increment req_addr modulo 2^ADDR_W.
REQ-022 SHALL, on that response, go to DONE if issued count equals NUM_REQ, else ISSUE.
REQ-023 SHALL set busy=1 in ISSUE and WAIT, done=1 only in DONE.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL ignore resp_valid in IDLE, ISSUE and DONE.
REQ-026 SHALL saturate hit_count and miss_count at 16'hFFFF.
REQ-027 SHALL wrap req_addr from 2^ADDR_W-1 to 0 without stopping the run.
REQ-028 SHALL guarantee hit_count+miss_count equals NUM_REQ in DONE (absent saturation).

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-run, immediately enter IDLE with req_valid=0, req_addr=0, busy=0, done=0, hit_count=0, miss_count=0, issued count=0, checksum=0.
REQ-030 SHALL not issue a request earlier than the first start pulse after rst_n deasserts.

Configuration
REQ-031 SHALL, with CACHE_REQ_CHECKSUM_EN defined, provide output checksum (32 bits) = modulo-2^32 sum of resp_data over accepted responses, cleared on start.
REQ-032 SHALL, without CACHE_REQ_CHECKSUM_EN, omit the checksum port and its adder entirely.

Verification
REQ-033 SHALL cover: NUM_REQ=4, START_ADDR=1024, cache always ready, resp_hit pattern 0,1,1,1 -> addresses 1024..1027 in order, done=1, hit_count=3, miss_count=1.
REQ-034 SHALL cover: req_ready held 0 for 5 cycles in ISSUE -> req_valid stays 1, req_addr unchanged, no count change.
REQ-035 SHALL cover: START_ADDR=32766, NUM_REQ=4, ADDR_W=15 -> addresses 32766, 32767, 0, 1.
REQ-036 SHALL cover: start pulsed during WAIT -> ignored; run completes with original NUM_REQ count.
REQ-037 SHALL cover: rst_n low during WAIT of 3rd request -> all outputs zero asynchronously; no req_valid until new start.
REQ-038 SHALL cover: with CACHE_REQ_CHECKSUM_EN, resp_data 32'hFFFFFFFF then 32'h2 -> checksum=32'h1.
